waveform_gen: RTL and testbench



---
 rtl/waveform_gen.sv | 72 +++++++
 tb/tb_waveform_gen.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/waveform_gen.sv
// waveform_gen: multi-channel square-wave generator with a run-length timer.
module waveform_gen #(
  parameter int NUM_CH = 3,
  parameter int DIV_W  = 16,
  parameter int RUN_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH*DIV_W-1:0] half_period,
  input  logic [RUN_W-1:0]        run_cycles,
  output logic [NUM_CH-1:0]       wave_out,
  output logic                    running,
  output logic                    done,
  output logic [RUN_W-1:0]        elapsed
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t            state_q;
  logic [DIV_W-1:0]  hp_q  [NUM_CH];
  logic [DIV_W-1:0]  cnt_q [NUM_CH];
  logic [DIV_W-1:0]  hp_d  [NUM_CH];
  logic [NUM_CH-1:0] wave_q;
  logic [RUN_W-1:0]  rc_q, el_q, el_d;
  // A zero half-period would never toggle, so it is floored to one cycle.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++)
      hp_d[i] = half_period[i*DIV_W +: DIV_W] == '0 ? DIV_W'(1) : half_period[i*DIV_W +: DIV_W];
    el_d = el_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wave_q  <= '0;
      rc_q    <= '0;
      el_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        hp_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else if (state_q == RUN) begin
      if (stop) state_q <= DONE;
      else begin
        el_q <= el_d;
        if (rc_q != '0 && el_d == rc_q) state_q <= DONE;
        for (int i = 0; i < NUM_CH; i++) begin
          if (!ch_en[i]) begin
            wave_q[i] <= 1'b0;
            cnt_q[i]  <= hp_q[i];
          end else if (cnt_q[i] == DIV_W'(1)) begin
            wave_q[i] <= ~wave_q[i];
            cnt_q[i]  <= hp_q[i];
          end else cnt_q[i] <= cnt_q[i] - 1'b1;
        end
      end
    end else if (start) begin
      state_q <= RUN;
      rc_q    <= run_cycles;
      el_q    <= '0;
      wave_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        hp_q[i]  <= hp_d[i];
        cnt_q[i] <= hp_d[i];
      end
    end
  end
  assign wave_out = wave_q;
  assign running  = state_q == RUN;
  assign done     = state_q == DONE;
  assign elapsed  = el_q;
endmodule

// File: tb/tb_waveform_gen.sv
// tb_waveform_gen: directed stimulus with a per-cycle reference model check.
module tb_waveform_gen;
  localparam int N = 3, DW = 16, RW = 32;
  logic clk = 0, rst_n = 0, start = 0, stop = 0, start8 = 0, stop8 = 0;
  logic [N-1:0]    ch_en = '1;
  logic [N*DW-1:0] half_period = '0;
  logic [RW-1:0]   run_cycles = '0;
  logic [7:0]      run8 = '0;
  logic [N-1:0]    wave_out, wave8;
  logic            running, done, running8, done8;
  logic [RW-1:0]   elapsed;
  logic [7:0]      elapsed8;

  waveform_gen #(.NUM_CH(N), .DIV_W(DW), .RUN_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .ch_en(ch_en),
    .half_period(half_period), .run_cycles(run_cycles),
    .wave_out(wave_out), .running(running), .done(done), .elapsed(elapsed));

  waveform_gen #(.NUM_CH(N), .DIV_W(DW), .RUN_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .stop(stop8), .ch_en(ch_en),
    .half_period(half_period), .run_cycles(run8),
    .wave_out(wave8), .running(running8), .done(done8), .elapsed(elapsed8));

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: each channel's wave is the parity of (enabled cycles since reload) / half-period.
  int            m_st;
  longint        m_hp [N];
  longint        m_age [N];
  longint        m_rc;
  logic [RW-1:0] m_el;
  logic [N-1:0]  m_wave;

  task automatic m_reset();
    m_st = 0; m_rc = 0; m_el = '0; m_wave = '0;
    for (int i = 0; i < N; i++) begin m_hp[i] = 0; m_age[i] = 0; end
  endtask

  task automatic m_step();
    if (m_st != 1) begin
      if (start) begin
        m_st = 1; m_rc = run_cycles; m_el = '0; m_wave = '0;
        for (int i = 0; i < N; i++) begin
          m_hp[i] = half_period[i*DW +: DW];
          if (m_hp[i] == 0) m_hp[i] = 1;
          m_age[i] = 0;
        end
      end
    end else if (stop) m_st = 2;
    else begin
      for (int i = 0; i < N; i++) begin
        if (ch_en[i]) begin
          m_age[i]++;
          m_wave[i] = ((m_age[i] / m_hp[i]) % 2) == 1;
        end else begin
          m_age[i] = 0;
          m_wave[i] = 1'b0;
        end
      end
      m_el = m_el + 1;
      if (m_rc != 0 && longint'(m_el) == m_rc) m_st = 2;
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  initial forever begin
    @(negedge clk);
    check("model_wave", wave_out, m_wave);
    check("model_running", running, m_st == 1);
    check("model_done", done, m_st == 2);
    check("model_elapsed", elapsed, m_el);
  end

  task automatic pulse_start();
    start = 1; @(negedge clk); start = 0;
  endtask

  task automatic pulse_stop();
    stop = 1; @(negedge clk); stop = 0;
  endtask

  int run_cnt, wraps, hi8;
  int tog [N];
  logic [N-1:0] prev;
  logic [7:0] prev8;

  initial begin
    half_period = {16'd100, 16'd10, 16'd1};
    run_cycles = 1000;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("idle_running", running, 0);
    check("idle_elapsed", elapsed, 0);

    // Fixed-length run: 1000 cycles.
    pulse_start();
    run_cnt = 0;
    for (int i = 0; i < N; i++) tog[i] = 0;
    prev = wave_out;
    for (int c = 0; c < 1010; c++) begin
      if (running) run_cnt++;
      for (int i = 0; i < N; i++) if (wave_out[i] != prev[i]) tog[i]++;
      prev = wave_out;
      @(negedge clk);
    end
    check("t1_running_cycles", run_cnt, 1000);
    check("t1_toggles_ch0", tog[0], 1000);
    check("t1_toggles_ch1", tog[1], 100);
    check("t1_toggles_ch2", tog[2], 10);
    check("t1_done", done, 1);
    check("t1_elapsed", elapsed, 1000);

    // Free-running, zero half-period, early stop.
    half_period = {16'd7, 16'd3, 16'd0};
    run_cycles = 0;
    pulse_start();
    repeat (50) @(negedge clk);
    check("t2_elapsed_pre", elapsed, 50);
    check("t2_wave_pre", wave_out, 3'b100);
    pulse_stop();
    check("t2_done", done, 1);
    check("t2_elapsed", elapsed, 50);
    check("t2_wave_frozen", wave_out, 3'b100);
    repeat (5) @(negedge clk);
    check("t2_wave_hold", wave_out, 3'b100);
    check("t2_done_hold", done, 1);

    // Channel disable / re-enable.
    half_period = {16'd5, 16'd4, 16'd2};
    pulse_start();
    repeat (20) @(negedge clk);
    ch_en = 3'b101;
    @(negedge clk);
    check("t3_ch1_off", wave_out[1], 0);
    repeat (19) @(negedge clk);
    ch_en = 3'b111;
    repeat (3) @(negedge clk);
    check("t3_ch1_before", wave_out[1], 0);
    @(negedge clk);
    check("t3_ch1_first", wave_out[1], 1);

    // Start and new half-periods ignored mid-run.
    half_period = {16'd9, 16'd9, 16'd9};
    pulse_start();
    check("t4_running", running, 1);
    check("t4_elapsed", elapsed, 45);
    pulse_stop();
    check("t4_done", done, 1);
    check("t4_elapsed_stop", elapsed, 45);
    pulse_start();
    check("t4_restart_elapsed", elapsed, 0);
    check("t4_restart_running", running, 1);
    repeat (8) @(negedge clk);
    check("t4_new_hp_low", wave_out, 3'b000);
    @(negedge clk);
    check("t4_new_hp_high", wave_out, 3'b111);

    // Asynchronous reset mid-run.
    repeat (291) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("t5_wave", wave_out, 0);
    check("t5_running", running, 0);
    check("t5_done", done, 0);
    check("t5_elapsed", elapsed, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (5) @(negedge clk);
    check("t5_idle_running", running, 0);
    check("t5_idle_elapsed", elapsed, 0);

    // Narrow elapsed counter wraps.
    start8 = 1; @(negedge clk); start8 = 0;
    wraps = 0; hi8 = 0; prev8 = elapsed8;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (elapsed8 < prev8) wraps++;
      if (running8) hi8++;
      prev8 = elapsed8;
    end
    check("t6_elapsed8", elapsed8, 88);
    check("t6_wraps", wraps, 2);
    check("t6_running8", hi8, 600);
    check("t6_done8", done8, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
